// File: rtl/bsg_link_bringup_pkg.sv
// Shared state encoding and sizing helpers for the link bring-up sequencer.
// The state encoding doubles as the state_o debug/LED encoding.
package bsg_link_bringup_pkg;

    typedef logic [2:0] bringup_state_t;

    localparam bringup_state_t PRE   = 3'd0;
    localparam bringup_state_t LRST  = 3'd1;
    localparam bringup_state_t LWAIT = 3'd2;
    localparam bringup_state_t LEN   = 3'd3;
    localparam bringup_state_t NODES = 3'd4;
    localparam bringup_state_t RUN   = 3'd5;

    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic int bringup_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One counter width serves every limit, so no counter ever has to wrap.
    function automatic int bringup_ctr_width(input int step_cycles,
                                             input int stagger_cycles,
                                             input int watchdog_cycles);
        return bsg_safe_clog2(bringup_max3(step_cycles, stagger_cycles, watchdog_cycles) + 1);
    endfunction

endpackage

// File: rtl/bsg_link_bringup_watchdog.sv
// RUN-state activity watchdog: counts silent cycles, clears on activity,
// and raises fire_o on the cycle the silent count reaches limit_p.
module bsg_link_bringup_watchdog
    import bsg_link_bringup_pkg::*;
#(
    parameter int width_p = 17,
    parameter int limit_p = 65536
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic activity_i,
    output logic fire_o
);

    localparam logic                 armed_lp = (limit_p != 0);
    localparam logic [width_p-1:0]   limit_lp = width_p'(limit_p);

    logic [width_p-1:0] count_r;

    assign fire_o = armed_lp & en_i & ~activity_i & (count_r == limit_lp);

    // A zero limit parks the counter so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i || activity_i || fire_o || !armed_lp) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_link_bringup_sequencer.sv
// Bring-up sequencer for one DDR link + channel tunnel: link reset pulse, link
// enable, chip-reset release, staggered node enables, then a watched RUN state.
module bsg_link_bringup_sequencer
    import bsg_link_bringup_pkg::*;
#(
    parameter int step_cycles_p     = 5000,
    parameter int num_nodes_p       = 2,
    parameter int stagger_cycles_p  = 16,
    parameter int watchdog_cycles_p = 65536
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   restart_i,
    input  logic                   activity_i,
    output logic                   link_reset_o,
    output logic                   link_enable_o,
    output logic                   chip_reset_o,
    output logic [num_nodes_p-1:0] node_en_o,
    output logic [2:0]             state_o,
    output logic                   done_o,
    output logic                   timeout_o
);

    localparam int ctr_width_lp = bringup_ctr_width(step_cycles_p, stagger_cycles_p,
                                                    watchdog_cycles_p);
    localparam int idx_width_lp = bsg_safe_clog2(num_nodes_p);

    localparam logic [ctr_width_lp-1:0] step_limit_lp    = ctr_width_lp'(step_cycles_p);
    localparam logic [ctr_width_lp-1:0] stagger_limit_lp = ctr_width_lp'(stagger_cycles_p);
    localparam logic [idx_width_lp-1:0] last_node_lp     = idx_width_lp'(num_nodes_p - 1);

    bringup_state_t            state_r;
    logic [ctr_width_lp-1:0]   count_r;
    logic [idx_width_lp-1:0]   node_idx_r;
    logic [ctr_width_lp-1:0]   limit;
    logic                      step_fire;
    logic                      wd_en;
    logic                      wd_fire;
    logic                      restart;

    assign state_o = state_r;

    // The first node waits a full step; later nodes only wait the stagger gap.
    assign limit     = (state_r == NODES && node_idx_r != '0) ? stagger_limit_lp : step_limit_lp;
    assign step_fire = (count_r == limit);

    // A registered timeout pulse is what triggers the watchdog restart one edge later.
    assign restart = restart_i | timeout_o;
    assign wd_en   = (state_r == RUN) && !timeout_o;

    bsg_link_bringup_watchdog #(
        .width_p (ctr_width_lp),
        .limit_p (watchdog_cycles_p)
    ) watchdog (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (wd_en),
        .activity_i (activity_i),
        .fire_o     (wd_fire)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i || restart) begin
            state_r       <= PRE;
            count_r       <= '0;
            node_idx_r    <= '0;
            link_reset_o  <= 1'b0;
            link_enable_o <= 1'b0;
            chip_reset_o  <= 1'b1;
            node_en_o     <= '0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state_r)
                PRE: begin
                    if (step_fire) begin
                        link_reset_o <= 1'b1;
                        state_r      <= LRST;
                        count_r      <= '0;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                LRST: begin
                    if (step_fire) begin
                        link_reset_o <= 1'b0;
                        state_r      <= LWAIT;
                        count_r      <= '0;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                LWAIT: begin
                    if (step_fire) begin
                        link_enable_o <= 1'b1;
                        state_r       <= LEN;
                        count_r       <= '0;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                LEN: begin
                    if (step_fire) begin
                        chip_reset_o <= 1'b0;
                        state_r      <= NODES;
                        node_idx_r   <= '0;
                        count_r      <= '0;
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                NODES: begin
                    if (step_fire) begin
                        node_en_o[node_idx_r] <= 1'b1;
                        count_r               <= '0;
                        if (node_idx_r == last_node_lp) begin
                            state_r <= RUN;
                            done_o  <= 1'b1;
                        end else begin
                            node_idx_r <= node_idx_r + 1'b1;
                        end
                    end else begin
                        count_r <= count_r + 1'b1;
                    end
                end
                RUN: begin
                    if (wd_fire) begin
                        timeout_o <= 1'b1;
                    end
                end
                default: begin
                    state_r <= PRE;
                    count_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_link_bringup_sequencer.sv
// Bench for the link bring-up sequencer: nominal timing table, watchdog,
// keep-alive, restart/collision/reset corner cases, and a 1-node no-watchdog config.
module tb_bsg_link_bringup_sequencer;
    import bsg_link_bringup_pkg::*;

    typedef struct {
        int         at;
        logic       act;
        logic [9:0] exp;
        string      tag;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_i, restart_i, activity_i;
    logic       rst2, restart2, activity2;

    logic       lr1, le1, cr1, done1, to1;
    logic [1:0] ne1;
    logic [2:0] st1;
    logic       lr2, le2, cr2, done2, to2;
    logic [0:0] ne2;
    logic [2:0] st2;

    logic [9:0] obs1, obs2;
    assign obs1 = {lr1, le1, cr1, ne1, done1, st1, to1};
    assign obs2 = {lr2, le2, cr2, 1'b0, ne2, done2, st2, to2};

    int   checks = 0;
    int   errors = 0;
    int   e = 0;
    bit   released = 0;
    bit   dut2_done = 0;
    vec_t vec[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    bsg_link_bringup_sequencer #(
        .step_cycles_p(4), .num_nodes_p(2), .stagger_cycles_p(2), .watchdog_cycles_p(20)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .restart_i(restart_i), .activity_i(activity_i),
        .link_reset_o(lr1), .link_enable_o(le1), .chip_reset_o(cr1), .node_en_o(ne1),
        .state_o(st1), .done_o(done1), .timeout_o(to1)
    );

    bsg_link_bringup_sequencer #(
        .step_cycles_p(4), .num_nodes_p(1), .stagger_cycles_p(2), .watchdog_cycles_p(0)
    ) dut2 (
        .clk_i(clk), .reset_i(rst2), .restart_i(restart2), .activity_i(activity2),
        .link_reset_o(lr2), .link_enable_o(le2), .chip_reset_o(cr2), .node_en_o(ne2),
        .state_o(st2), .done_o(done2), .timeout_o(to2)
    );

    function automatic logic [9:0] pk(logic lr, logic le, logic cr, logic [1:0] ne,
                                      logic done, logic [2:0] st, logic to);
        return {lr, le, cr, ne, done, st, to};
    endfunction

    function automatic vec_t mk(int at, logic act, logic [9:0] x, string tag);
        vec_t v;
        v.at = at; v.act = act; v.exp = x; v.tag = tag;
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic advance_to(int at);
        while (e < at) tick();
    endtask

    task automatic expect_at(int at, logic [9:0] x, string tag);
        vec_t r;
        sb.push_back(mk(at, activity_i, x, tag));
        advance_to(at);
        r = sb.pop_front();
        check($sformatf("%s@%0d", r.tag, e), {22'd0, obs1}, {22'd0, r.exp});
    endtask

    logic [9:0] rstv;
    logic [9:0] runv;

    initial begin
        int a, c, to_seen, not_done;
        vec_t r;
        rstv = pk(0, 0, 1, 2'b00, 0, PRE, 0);
        runv = pk(0, 1, 0, 2'b11, 1, RUN, 0);

        vec.push_back(mk(0,  1, rstv,                              "reset_state"));
        vec.push_back(mk(4,  1, rstv,                              "pre_hold"));
        vec.push_back(mk(5,  1, pk(1, 0, 1, 2'b00, 0, LRST, 0),    "lrst_rise"));
        vec.push_back(mk(9,  1, pk(1, 0, 1, 2'b00, 0, LRST, 0),    "lrst_hold"));
        vec.push_back(mk(10, 1, pk(0, 0, 1, 2'b00, 0, LWAIT, 0),   "lrst_fall"));
        vec.push_back(mk(14, 1, pk(0, 0, 1, 2'b00, 0, LWAIT, 0),   "lwait_hold"));
        vec.push_back(mk(15, 1, pk(0, 1, 1, 2'b00, 0, LEN, 0),     "link_enable"));
        vec.push_back(mk(19, 1, pk(0, 1, 1, 2'b00, 0, LEN, 0),     "len_hold"));
        vec.push_back(mk(20, 1, pk(0, 1, 0, 2'b00, 0, NODES, 0),   "chip_reset_fall"));
        vec.push_back(mk(24, 1, pk(0, 1, 0, 2'b00, 0, NODES, 0),   "node0_wait"));
        vec.push_back(mk(25, 1, pk(0, 1, 0, 2'b01, 0, NODES, 0),   "node0_en"));
        vec.push_back(mk(27, 1, pk(0, 1, 0, 2'b01, 0, NODES, 0),   "stagger_wait"));
        vec.push_back(mk(28, 0, runv,                              "run_entry"));
        vec.push_back(mk(48, 0, runv,                              "wd_silent"));
        vec.push_back(mk(49, 0, pk(0, 1, 0, 2'b11, 1, RUN, 1),     "wd_timeout"));
        vec.push_back(mk(50, 0, rstv,                              "wd_restart"));
        vec.push_back(mk(54, 0, rstv,                              "rerun_pre"));
        vec.push_back(mk(55, 0, pk(1, 0, 1, 2'b00, 0, LRST, 0),    "rerun_lrst"));
        vec.push_back(mk(78, 0, runv,                              "rerun_run"));

        reset_i = 1'b1; restart_i = 1'b0; activity_i = 1'b1;
        rst2 = 1'b1; restart2 = 1'b0; activity2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        e = 0;
        reset_i = 1'b0;
        rst2 = 1'b0;
        released = 1'b1;

        foreach (vec[i]) begin
            sb.push_back(vec[i]);
            advance_to(vec[i].at);
            r = sb.pop_front();
            check($sformatf("%s@%0d", r.tag, e), {22'd0, obs1}, {22'd0, r.exp});
            activity_i = r.act;
        end

        to_seen = 0;
        not_done = 0;
        for (int k = 0; k < 500; k++) begin
            activity_i = (k % 15 == 0);
            tick();
            if (to1) to_seen++;
            if (!done1) not_done++;
        end
        check("keepalive_timeouts", to_seen, 0);
        check("keepalive_done_drops", not_done, 0);

        activity_i = 1'b1;
        tick();
        a = e;
        activity_i = 1'b0;
        expect_at(a + 20, runv, "pre_collision");
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        check($sformatf("collision@%0d", e), {22'd0, obs1}, {22'd0, rstv});
        c = e;
        expect_at(c + 1, rstv, "collision_after");
        expect_at(c + 5, pk(1, 0, 1, 2'b00, 0, LRST, 0), "restart_lrst");
        expect_at(c + 10, pk(0, 0, 1, 2'b00, 0, LWAIT, 0), "in_lwait");
        advance_to(c + 11);
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        check($sformatf("restart_lwait@%0d", e), {22'd0, obs1}, {22'd0, rstv});
        expect_at(c + 16, rstv, "restart_pre_hold");
        expect_at(c + 17, pk(1, 0, 1, 2'b00, 0, LRST, 0), "restart_lrst_rise");
        expect_at(c + 40, runv, "restart_run");
        advance_to(c + 44);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check($sformatf("reset_in_run@%0d", e), {22'd0, obs1}, {22'd0, rstv});
        expect_at(c + 50, pk(1, 0, 1, 2'b00, 0, LRST, 0), "post_reset_lrst");

        for (int k = 0; k < 3000 && !dut2_done; k++) @(posedge clk);
        check("dut2_finished", {31'd0, dut2_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int bad;
        wait (released);
        repeat (24) @(posedge clk);
        #1;
        check("one_node_wait", {22'd0, obs2}, {22'd0, pk(0, 1, 0, 2'b00, 0, NODES, 0)});
        @(posedge clk);
        #1;
        check("one_node_run", {22'd0, obs2}, {22'd0, pk(0, 1, 0, 2'b01, 1, RUN, 0)});
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (obs2 !== pk(0, 1, 0, 2'b01, 1, RUN, 0)) bad++;
        end
        check("one_node_idle_hold", bad, 0);
        dut2_done = 1'b1;
    end

endmodule
